mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum cycles waiting on dbus_gnt or dbus_rvalid before a bus error.
REQ-002 SHALL have ports, one per line, each as name  direction  width  meaning:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_valid  in  1  EX presents an instruction.
- ex_ready  out  1  stage accepts; transfer when ex_valid&&ex_ready.
- ex_mem_op  in  4  NONE/LB/LBU/LH/LHU/LW/SB/SH/SW encoding, from the shared header.
- ex_result  in  `DATA_BUS  EX result; the effective address for memory ops.
- ex_store_data  in  `DATA_BUS  store operand.
- ex_wb_en  in  1  register write enable.
- ex_wb_reg  in  5  destination register.
- flush  in  1  discard the held instruction.
- dbus_req  out  1  bus request.
- dbus_we  out  1  write.
- dbus_addr  out  `DATA_BUS  word-aligned address.
- dbus_be  out  4  byte enables.
- dbus_wdata  out  `DATA_BUS  lane-replicated store data.
- dbus_gnt  in  1  request accepted.
- dbus_rvalid  in  1  read data valid.
- dbus_rdata  in  `DATA_BUS  read data.
- wb_valid  out  1  WB result valid, one-cycle pulse.
- wb_en  out  1  write enable to WB.
- wb_reg  out  5  destination register to WB.
- wb_data  out  `DATA_BUS  result to WB.
- excp_valid  out  1  exception pulse.
- excp_code  out  2  exception cause: 1=load misalign, 2=store misalign, 3=bus error.
- excp_badvaddr  out  `DATA_BUS  faulting address.

Function
REQ-003 SHALL implement FSM IDLE, REQ, WAIT, DONE.
REQ-004 SHALL assert ex_ready only in IDLE, or in DONE (back-to-back acceptance).
REQ-005 SHALL handle a NONE op by registering ex_result to wb_data, moving to DONE, and pulsing wb_valid the next cycle; latency is 1.
REQ-006 SHALL handle a memory op on acceptance by moving to REQ and holding dbus_req with stable addr/be/wdata/we until dbus_gnt.
REQ-007 SHALL, on dbus_gnt for a store, move to DONE with wb_en=0.
REQ-008 SHALL, on dbus_gnt for a load, move to WAIT.
REQ-009 SHALL, on dbus_rvalid in WAIT, capture the extracted lane into wb_data and move to DONE.
REQ-010 SHALL treat dbus_gnt and dbus_rvalid asserted in the same cycle while in REQ as complete, going directly to DONE.
REQ-011 SHALL generate byte enables as follows:
- SB: 4'b0001<<addr[1:0].
- SH: 4'b0011<<{addr[1],1'b0}.
- SW: 4'b1111.
- loads: 4'b1111.
REQ-012 SHALL replicate store data across lanes as follows:
- SB: data[7:0] x4.
- SH: data[15:0] x2.
REQ-013 SHALL extend load data as follows:
- LB and LH: sign-extend the selected byte or halfword.
- LBU and LHU: zero-extend.
- LW: pass unchanged.
REQ-014 SHALL, in DONE, pulse wb_valid and then return to IDLE, or to REQ/DONE if a new op is accepted in the same cycle.
REQ-015 SHALL count cycles in REQ or WAIT; on reaching TIMEOUT it drops dbus_req, pulses excp_valid with code 3, sets excp_badvaddr, suppresses wb_valid, and returns to IDLE.
REQ-016 SHALL, on flush in REQ before grant, drop dbus_req and go to IDLE without wb_valid.
REQ-017 SHALL, on flush in WAIT, go to a drain mode that discards the pending rvalid; ex_ready stays 0 until that rvalid or the timeout.
REQ-018 SHALL, on flush in DONE, suppress wb_valid.
REQ-019 SHALL, on flush coincident with acceptance, not accept the instruction.

Reset
REQ-020 SHALL, when rst_n is low, asynchronously force:
- FSM to IDLE.
- counter to 0.
- dbus_req, dbus_we, wb_valid, wb_en, excp_valid to 0.
- dbus_be to 0; wb_reg to 0; all data and address outputs to 0.
REQ-021 SHALL treat reset asserted mid-transaction as abandoning it; no response is expected after reset deassertion.

Configuration
REQ-022 SHALL, with MEM_ALIGN_CHECK_EN defined, treat misaligned LH/LHU/SH (addr[0]) and LW/SW (addr[1:0]!=0) as follows:
- no bus request is issued.
- excp_valid pulses the cycle after acceptance, with code 1 or 2 and excp_badvaddr=address.
- no wb_valid is produced.
REQ-023 SHALL, without MEM_ALIGN_CHECK_EN, force the low address bits to the access size alignment and issue the access normally; excp codes 1 and 2 never occur.

Structure
REQ-024 SHALL take the mem_op encodings, excp codes and the `DATA_BUS width from the shared core defines header; no local duplicates.
REQ-025 SHALL place lane selection and extension in a combinational sub-module mem_align (byte enables, store replication, load extension).

Verification
REQ-026 SHALL pass: NONE op with ex_result=0x1234 -> wb_valid one cycle later, wb_data=0x1234.
REQ-027 SHALL pass: LB at addr 0x103, rdata=0x80FFFFFF -> wb_data=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-028 SHALL pass: SH at addr 0x202, data=0xABCD1234, gnt delayed 3 cycles -> dbus_req held for 4 cycles, be=4'b1100, wdata=0x12341234, wb_en=0.
REQ-029 SHALL pass: LW at 0x101 with MEM_ALIGN_CHECK_EN -> excp_valid, code 1, badvaddr=0x101, no dbus_req.
REQ-030 SHALL pass: LW with dbus_gnt never asserted, TIMEOUT=8 -> code 3 after 8 cycles, return to IDLE, ex_ready=1.
REQ-031 SHALL pass: flush in WAIT, then late rvalid -> no wb_valid; the next LW completes correctly.

Source files
------------

// File: rtl/mem_access_pkg.sv
// +-----------------------------------------------------------------------------
// | mem_access_pkg : shared core defines (DATA_BUS, mem_op, excp codes) plus
// | the mem_access FSM state type and op-class helpers.     Rev 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

`ifndef CORE_DEFINES_SVH
`define CORE_DEFINES_SVH
`define DATA_BUS            31:0
`define MEM_OP_NONE         4'd0
`define MEM_OP_LB           4'd1
`define MEM_OP_LBU          4'd2
`define MEM_OP_LH           4'd3
`define MEM_OP_LHU          4'd4
`define MEM_OP_LW           4'd5
`define MEM_OP_SB           4'd6
`define MEM_OP_SH           4'd7
`define MEM_OP_SW           4'd8
`define EXCP_LOAD_MISALIGN  2'd1
`define EXCP_STORE_MISALIGN 2'd2
`define EXCP_BUS_ERR        2'd3
`endif

package mem_access_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic is_load(input logic [3:0] op);
    return op inside {`MEM_OP_LB, `MEM_OP_LBU, `MEM_OP_LH, `MEM_OP_LHU, `MEM_OP_LW};
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return op inside {`MEM_OP_SB, `MEM_OP_SH, `MEM_OP_SW};
  endfunction

  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] off);
    case (op)
      `MEM_OP_LH, `MEM_OP_LHU, `MEM_OP_SH: return off[0];
      `MEM_OP_LW, `MEM_OP_SW:              return off != 2'b00;
      default:                             return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_align.sv
// +-----------------------------------------------------------------------------
// | mem_align : combinational lane logic - byte enables, store replication and
// | load lane extraction with sign/zero extension.          Rev 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module mem_align (
  input  logic [3:0]       i_req_op,
  input  logic [1:0]       i_req_off,
  input  logic [`DATA_BUS] i_store_data,
  output logic [3:0]       o_be,
  output logic [`DATA_BUS] o_wdata,
  input  logic [3:0]       i_rsp_op,
  input  logic [1:0]       i_rsp_off,
  input  logic [`DATA_BUS] i_rdata,
  output logic [`DATA_BUS] o_load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_store_data;
    case (i_req_op)
      `MEM_OP_SB: begin
        o_be    = 4'b0001 << i_req_off;
        o_wdata = {4{i_store_data[7:0]}};
      end
      `MEM_OP_SH: begin
        o_be    = 4'b0011 << {i_req_off[1], 1'b0};
        o_wdata = {2{i_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (i_rsp_off)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_rsp_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_rsp_op)
      `MEM_OP_LB:  o_load_data = {{24{w_byte[7]}}, w_byte};
      `MEM_OP_LBU: o_load_data = {24'd0, w_byte};
      `MEM_OP_LH:  o_load_data = {{16{w_half[15]}}, w_half};
      `MEM_OP_LHU: o_load_data = {16'd0, w_half};
      default:     o_load_data = i_rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access.sv
// +-----------------------------------------------------------------------------
// | mem_access : MEM stage - drives the data bus for loads/stores and returns
// | results to WB. Define MEM_ALIGN_CHECK_EN to trap misaligned accesses.  Rev 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic [3:0]       ex_mem_op,
  input  logic [`DATA_BUS] ex_result,
  input  logic [`DATA_BUS] ex_store_data,
  input  logic             ex_wb_en,
  input  logic [4:0]       ex_wb_reg,
  input  logic             flush,
  output logic             dbus_req,
  output logic             dbus_we,
  output logic [`DATA_BUS] dbus_addr,
  output logic [3:0]       dbus_be,
  output logic [`DATA_BUS] dbus_wdata,
  input  logic             dbus_gnt,
  input  logic             dbus_rvalid,
  input  logic [`DATA_BUS] dbus_rdata,
  output logic             wb_valid,
  output logic             wb_en,
  output logic [4:0]       wb_reg,
  output logic [`DATA_BUS] wb_data,
  output logic             excp_valid,
  output logic [1:0]       excp_code,
  output logic [`DATA_BUS] excp_badvaddr
);

  localparam int c_CNT_W = $clog2(TIMEOUT + 1);

  state_t             r_state;
  logic               r_drain;
  logic [c_CNT_W-1:0] r_cnt;
  logic [3:0]         r_op;
  logic [`DATA_BUS]   r_addr;
  logic               r_wb_valid;

  logic [3:0]         w_be;
  logic [`DATA_BUS]   w_wdata;
  logic [`DATA_BUS]   w_load_data;
  logic               w_accept;
  logic               w_timeout;
  logic               w_misalign;

  mem_align u_align (
    .i_req_op     (ex_mem_op),
    .i_req_off    (ex_result[1:0]),
    .i_store_data (ex_store_data),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .i_rsp_op     (r_op),
    .i_rsp_off    (r_addr[1:0]),
    .i_rdata      (dbus_rdata),
    .o_load_data  (w_load_data)
  );

  assign ex_ready  = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_accept  = ex_valid && ex_ready && !flush;
  assign w_timeout = (r_cnt == c_CNT_W'(TIMEOUT - 1));
  // The DONE pulse is already registered; a flush in that cycle masks it.
  assign wb_valid  = r_wb_valid && !flush;

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = is_misaligned(ex_mem_op, ex_result[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_drain       <= 1'b0;
      r_cnt         <= '0;
      r_op          <= `MEM_OP_NONE;
      r_addr        <= '0;
      r_wb_valid    <= 1'b0;
      dbus_req      <= 1'b0;
      dbus_we       <= 1'b0;
      dbus_addr     <= '0;
      dbus_be       <= 4'b0000;
      dbus_wdata    <= '0;
      wb_en         <= 1'b0;
      wb_reg        <= 5'd0;
      wb_data       <= '0;
      excp_valid    <= 1'b0;
      excp_code     <= 2'd0;
      excp_badvaddr <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      excp_valid <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_state <= ST_IDLE;
          if (w_accept) begin
            r_op   <= ex_mem_op;
            r_addr <= ex_result;
            r_cnt  <= '0;
            wb_reg <= ex_wb_reg;
            if (ex_mem_op == `MEM_OP_NONE) begin
              wb_data    <= ex_result;
              wb_en      <= ex_wb_en;
              r_wb_valid <= 1'b1;
              r_state    <= ST_DONE;
            end else if (w_misalign) begin
              excp_valid    <= 1'b1;
              excp_code     <= is_load(ex_mem_op) ? `EXCP_LOAD_MISALIGN : `EXCP_STORE_MISALIGN;
              excp_badvaddr <= ex_result;
            end else begin
              r_state    <= ST_REQ;
              dbus_req   <= 1'b1;
              dbus_we    <= is_store(ex_mem_op);
              dbus_addr  <= {ex_result[31:2], 2'b00};
              dbus_be    <= w_be;
              dbus_wdata <= w_wdata;
              wb_en      <= ex_wb_en && is_load(ex_mem_op);
            end
          end
        end

        ST_REQ: begin
          r_cnt <= r_cnt + 1'b1;
          if (dbus_gnt) begin
            dbus_req <= 1'b0;
            if (!is_load(r_op)) begin
              r_wb_valid <= !flush;
              r_state    <= flush ? ST_IDLE : ST_DONE;
            end else if (dbus_rvalid) begin
              wb_data    <= w_load_data;
              r_wb_valid <= !flush;
              r_state    <= flush ? ST_IDLE : ST_DONE;
            end else begin
              r_drain <= flush;
              r_state <= ST_WAIT;
            end
          end else if (flush) begin
            dbus_req <= 1'b0;
            r_state  <= ST_IDLE;
          end else if (w_timeout) begin
            dbus_req      <= 1'b0;
            excp_valid    <= 1'b1;
            excp_code     <= `EXCP_BUS_ERR;
            excp_badvaddr <= r_addr;
            r_state       <= ST_IDLE;
          end
        end

        ST_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (dbus_rvalid) begin
            r_drain <= 1'b0;
            if (r_drain || flush) begin
              r_state <= ST_IDLE;
            end else begin
              wb_data    <= w_load_data;
              r_wb_valid <= 1'b1;
              r_state    <= ST_DONE;
            end
          end else if (w_timeout) begin
            // A flushed load that never returns data is not reported.
            r_drain <= 1'b0;
            r_state <= ST_IDLE;
            if (!r_drain && !flush) begin
              excp_valid    <= 1'b1;
              excp_code     <= `EXCP_BUS_ERR;
              excp_badvaddr <= r_addr;
            end
          end else if (flush) begin
            r_drain <= 1'b1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
// +-----------------------------------------------------------------------------
// | tb_mem_access : directed vectors with a queue scoreboard checked by an
// | independent WB/exception monitor.                       Rev 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [3:0]  ex_mem_op = `MEM_OP_NONE;
  logic [31:0] ex_result = '0;
  logic [31:0] ex_store_data = '0;
  logic        ex_wb_en = 1'b0;
  logic [4:0]  ex_wb_reg = '0;
  logic        flush = 1'b0;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [3:0]  dbus_be;
  logic        dbus_gnt = 1'b0;
  logic        dbus_rvalid = 1'b0;
  logic [31:0] dbus_rdata = '0;
  logic        wb_valid, wb_en, excp_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data, excp_badvaddr;
  logic [1:0]  excp_code;

  mem_access #(.TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_mem_op(ex_mem_op),
    .ex_result(ex_result), .ex_store_data(ex_store_data),
    .ex_wb_en(ex_wb_en), .ex_wb_reg(ex_wb_reg), .flush(flush),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_be(dbus_be), .dbus_wdata(dbus_wdata), .dbus_gnt(dbus_gnt),
    .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
    .wb_valid(wb_valid), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .excp_valid(excp_valid), .excp_code(excp_code), .excp_badvaddr(excp_badvaddr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_excp;
    logic        en;
    logic [4:0]  rg;
    logic [31:0] data;
    bit          chk_data;
    logic [1:0]  code;
    logic [31:0] badv;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_miss = 0;

  // Bus activity seen since the last acceptance
  int          req_cnt = 0;
  logic [3:0]  last_be;
  logic [31:0] last_wdata, last_addr;
  logic        last_we;

  always @(negedge clk) begin
    if (dbus_req) begin
      req_cnt++;
      last_be    = dbus_be;
      last_wdata = dbus_wdata;
      last_addr  = dbus_addr;
      last_we    = dbus_we;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic exp_t wb_exp(input logic en, input logic [4:0] rg,
                                  input logic [31:0] data, input bit chk);
    exp_t e;
    e.is_excp = 1'b0; e.en = en; e.rg = rg; e.data = data; e.chk_data = chk;
    e.code = 2'd0; e.badv = '0;
    return e;
  endfunction

  function automatic exp_t ex_exp(input logic [1:0] code, input logic [31:0] badv);
    exp_t e;
    e.is_excp = 1'b1; e.en = 1'b0; e.rg = '0; e.data = '0; e.chk_data = 1'b0;
    e.code = code; e.badv = badv;
    return e;
  endfunction

  // Monitor: every WB or exception pulse must match the head of the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (wb_valid || excp_valid)) begin
        if (sb_q.size() == 0) begin
          check("unexpected_output", {30'd0, wb_valid, excp_valid}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("out_kind", {31'd0, excp_valid}, {31'd0, e.is_excp});
          if (e.is_excp) begin
            check("excp_code", {30'd0, excp_code}, {30'd0, e.code});
            check("excp_badvaddr", excp_badvaddr, e.badv);
          end else begin
            check("wb_en", {31'd0, wb_en}, {31'd0, e.en});
            check("wb_reg", {27'd0, wb_reg}, {27'd0, e.rg});
            if (e.chk_data) check("wb_data", wb_data, e.data);
          end
        end
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic en, input logic [4:0] rg);
    int n;
    @(negedge clk);
    ex_valid = 1'b1; ex_mem_op = op; ex_result = addr;
    ex_store_data = sdata; ex_wb_en = en; ex_wb_reg = rg;
    n = 0;
    while (!ex_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ex_ready) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    ex_valid = 1'b0; ex_mem_op = `MEM_OP_NONE;
    req_cnt = 0;
  endtask

  task automatic bus(input int gdly, input bit ld, input int rdly, input logic [31:0] rdata);
    repeat (gdly) @(posedge clk);
    if (gdly > 0) #1;
    dbus_gnt = 1'b1;
    if (ld && rdly == 0) begin
      dbus_rvalid = 1'b1; dbus_rdata = rdata;
    end
    @(posedge clk);
    #1;
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
    if (ld && rdly > 0) begin
      repeat (rdly - 1) @(posedge clk);
      if (rdly > 1) #1;
      dbus_rvalid = 1'b1; dbus_rdata = rdata;
      @(posedge clk);
      #1;
      dbus_rvalid = 1'b0;
    end
  endtask

  task automatic do_load(input logic [3:0] op, input logic [31:0] addr, input logic [4:0] rg,
                         input int gdly, input int rdly, input logic [31:0] rdata,
                         input logic [31:0] exp_data);
    sb_q.push_back(wb_exp(1'b1, rg, exp_data, 1'b1));
    issue(op, addr, 32'd0, 1'b1, rg);
    bus(gdly, 1'b1, rdly, rdata);
  endtask

  task automatic do_store(input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [4:0] rg, input int gdly);
    sb_q.push_back(wb_exp(1'b0, rg, 32'd0, 1'b0));
    issue(op, addr, sdata, 1'b1, rg);
    bus(gdly, 1'b0, 0, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got 0 expected 1");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #12;
    check("rst_dbus_req", {31'd0, dbus_req}, 32'd0);
    check("rst_dbus_be", {28'd0, dbus_be}, 32'd0);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_excp_valid", {31'd0, excp_valid}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_dbus_addr", dbus_addr, 32'd0);
    check("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // NONE op: result one cycle after acceptance
    sb_q.push_back(wb_exp(1'b1, 5'd5, 32'h0000_1234, 1'b1));
    issue(`MEM_OP_NONE, 32'h0000_1234, 32'd0, 1'b1, 5'd5);
    @(negedge clk);
    check("none_latency", {31'd0, wb_valid}, 32'd1);

    do_load(`MEM_OP_LB,  32'h103, 5'd6, 0, 1, 32'h80FF_FFFF, 32'hFFFF_FF80);
    do_load(`MEM_OP_LBU, 32'h103, 5'd7, 0, 0, 32'h80FF_FFFF, 32'h0000_0080);

    // SH with grant after 3 waiting cycles
    do_store(`MEM_OP_SH, 32'h202, 32'hABCD_1234, 5'd8, 3);
    check("sh_req_cycles", req_cnt, 32'd4);
    check("sh_be", {28'd0, last_be}, 32'h0000_000C);
    check("sh_wdata", last_wdata, 32'h1234_1234);
    check("sh_addr", last_addr, 32'h0000_0200);
    check("sh_we", {31'd0, last_we}, 32'd1);

    do_store(`MEM_OP_SB, 32'h101, 32'h0000_0055, 5'd9, 1);
    check("sb_be", {28'd0, last_be}, 32'h0000_0002);
    check("sb_wdata", last_wdata, 32'h5555_5555);

    do_load(`MEM_OP_LH,  32'h202, 5'd10, 0, 1, 32'h8001_7FFF, 32'hFFFF_8001);
    do_load(`MEM_OP_LHU, 32'h200, 5'd11, 1, 0, 32'h8001_7FFF, 32'h0000_7FFF);
    do_load(`MEM_OP_LW,  32'h300, 5'd12, 1, 2, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    check("lw_be", {28'd0, last_be}, 32'h0000_000F);
    check("lw_we", {31'd0, last_we}, 32'd0);

`ifdef MEM_ALIGN_CHECK_EN
    sb_q.push_back(ex_exp(2'd1, 32'h101));
    issue(`MEM_OP_LW, 32'h101, 32'd0, 1'b1, 5'd13);
    repeat (3) @(negedge clk);
    check("misalign_lw_noreq", req_cnt, 32'd0);
    sb_q.push_back(ex_exp(2'd2, 32'h203));
    issue(`MEM_OP_SH, 32'h203, 32'hFFFF_0000, 1'b1, 5'd14);
    repeat (3) @(negedge clk);
    check("misalign_sh_noreq", req_cnt, 32'd0);
`else
    do_load(`MEM_OP_LW, 32'h101, 5'd13, 0, 1, 32'h0102_0304, 32'h0102_0304);
    check("align_lw_addr", last_addr, 32'h0000_0100);
    do_load(`MEM_OP_LH, 32'h203, 5'd14, 0, 1, 32'hFEDC_0000, 32'hFFFF_FEDC);
`endif

    // Grant never arrives: bus error after 8 cycles
    sb_q.push_back(ex_exp(2'd3, 32'h400));
    issue(`MEM_OP_LW, 32'h400, 32'd0, 1'b1, 5'd15);
    repeat (9) @(negedge clk);
    check("timeout_req_cycles", req_cnt, 32'd8);
    check("timeout_ex_ready", {31'd0, ex_ready}, 32'd1);

    // Flush in WAIT, late rvalid is drained
    issue(`MEM_OP_LW, 32'h500, 32'd0, 1'b1, 5'd16);
    dbus_gnt = 1'b1;
    @(posedge clk); #1;
    dbus_gnt = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("drain_ex_ready", {31'd0, ex_ready}, 32'd0);
    @(posedge clk); #1;
    dbus_rvalid = 1'b1; dbus_rdata = 32'h0000_0BAD;
    @(posedge clk); #1;
    dbus_rvalid = 1'b0;
    @(negedge clk);
    check("drain_done_ready", {31'd0, ex_ready}, 32'd1);
    do_load(`MEM_OP_LW, 32'h504, 5'd17, 0, 1, 32'h1122_3344, 32'h1122_3344);

    // Flush in REQ before grant
    issue(`MEM_OP_SW, 32'h600, 32'h7777_7777, 1'b0, 5'd18);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_req_dropped", {31'd0, dbus_req}, 32'd0);
    check("flush_req_cycles", req_cnt, 32'd2);

    // Flush in DONE masks wb_valid
    issue(`MEM_OP_NONE, 32'h0000_BEEF, 32'd0, 1'b1, 5'd19);
    flush = 1'b1;
    @(negedge clk);
    check("flush_done_wb", {31'd0, wb_valid}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;

    // Flush coincident with offered instruction: not accepted
    @(negedge clk);
    ex_valid = 1'b1; ex_mem_op = `MEM_OP_LW; ex_result = 32'h800; flush = 1'b1;
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_mem_op = `MEM_OP_NONE; flush = 1'b0;
    @(negedge clk);
    check("flush_accept_noreq", {31'd0, dbus_req}, 32'd0);

    // Back-to-back NONE ops accepted from DONE
    sb_q.push_back(wb_exp(1'b1, 5'd1, 32'h0000_1111, 1'b1));
    sb_q.push_back(wb_exp(1'b0, 5'd2, 32'h0000_2222, 1'b1));
    issue(`MEM_OP_NONE, 32'h0000_1111, 32'd0, 1'b1, 5'd1);
    ex_valid = 1'b1; ex_result = 32'h0000_2222; ex_wb_en = 1'b0; ex_wb_reg = 5'd2;
    @(negedge clk);
    check("b2b_ready_in_done", {31'd0, ex_ready}, 32'd1);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    @(negedge clk);
    check("b2b_second_valid", {31'd0, wb_valid}, 32'd1);

    // Reset mid-transaction abandons it
    issue(`MEM_OP_LW, 32'h700, 32'd0, 1'b1, 5'd20);
    rst_n = 1'b0;
    #1;
    check("midrst_req", {31'd0, dbus_req}, 32'd0);
    check("midrst_wb_reg", {27'd0, wb_reg}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
